// File: rtl/sweep_sequencer_pkg.sv
// Shared definitions for the sweep sequencer and its triangle-count consumers:
// default count/bound width, default sweep-request width and the FSM state encoding.
package sweep_sequencer_pkg;

  // Default width of the count value and of the lo/hi bounds
  localparam int unsigned SS_WIDTH = 3;
  // Default width of the sweep-count request (max sweeps = 2^SS_CNT_W-1)
  localparam int unsigned SS_CNT_W = 4;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage : sweep_sequencer_pkg

// File: rtl/sweep_sequencer_counter.sv
// bounded_updown_counter: loadable up/down counter. The bounds are enforced by
// the controller, which never steps the count past hi or below lo, so the
// arithmetic here can never wrap.
//
// Ports:
//   clk      - clock, all updates on posedge
//   rst      - synchronous active-high reset, count returns to 0
//   load     - load load_val (has priority over en)
//   load_val - value loaded when load is high
//   en       - step the count by one in the direction given by up
//   up       - 1 = increment, 0 = decrement
//   count    - current count (registered)
module bounded_updown_counter
  import sweep_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = SS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count register: reset, load, then step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      if (up) begin
        r_count <= r_count + WIDTH'(1);
      end else begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

  assign count = r_count;

endmodule : bounded_updown_counter

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: runs a bounded triangle count lo->hi->lo for a programmed
// number of sweeps, with start/done handshaking and a hold input.
//
// Ports:
//   clk      - clock, all updates on posedge
//   rst      - synchronous active-high reset
//   start    - one-cycle request, only accepted in IDLE
//   lo, hi   - sweep bounds (unsigned), latched on an accepted start
//   n_sweeps - number of full lo->hi->lo sweeps, latched on an accepted start
//   hold     - freezes sequencing while high in UP/DOWN
//   count    - current counter value
//   dir      - 1 = counting up or not sweeping, 0 = counting down
//   busy     - high while sweeping (UP/DOWN)
//   done     - one-cycle pulse on completion or on a rejected configuration
module sweep_sequencer
  import sweep_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = SS_WIDTH,
  parameter int unsigned CNT_W = SS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CNT_W-1:0] n_sweeps,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_next_state;

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_sweep;

  logic             r_busy;
  logic             r_done;
  logic             r_dir;

  logic [WIDTH-1:0] w_count;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_en;
  logic             w_up;
  logic             w_cfg_latch;
  logic             w_sweep_clr;
  logic             w_sweep_inc;

  logic             w_cfg_reject;
  logic             w_at_hi;
  logic             w_at_lo;
  logic             w_last_sweep;

  // Compare logic against the live request and the latched configuration
  assign w_cfg_reject = (hi <= lo) || (n_sweeps == '0);
  assign w_at_hi      = (w_count == r_hi);
  assign w_at_lo      = (w_count == r_lo);
  assign w_last_sweep = ((r_sweep + CNT_W'(1)) == r_n);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and counter control
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = r_lo;
    w_en         = 1'b0;
    w_up         = 1'b1;
    w_cfg_latch  = 1'b0;
    w_sweep_clr  = 1'b0;
    w_sweep_inc  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cfg_latch = 1'b1;
          if (w_cfg_reject) begin
            // Count is left untouched on a rejected configuration
            w_next_state = ST_FIN;
          end else begin
            w_load       = 1'b1;
            w_load_val   = lo;
            w_sweep_clr  = 1'b1;
            w_next_state = ST_UP;
          end
        end
      end

      ST_UP: begin
        if (!hold) begin
          w_en = 1'b1;
          if (w_at_hi) begin
            // Peak shown for one cycle, then turn around immediately
            w_up         = 1'b0;
            w_next_state = ST_DOWN;
          end else begin
            w_up = 1'b1;
          end
        end
      end

      ST_DOWN: begin
        if (!hold) begin
          if (!w_at_lo) begin
            w_en = 1'b1;
            w_up = 1'b0;
          end else if (w_last_sweep) begin
            w_next_state = ST_FIN;
          end else begin
            // Trough shown for one cycle: reload lo+1 (lo<hi, so no wrap)
            w_sweep_inc  = 1'b1;
            w_load       = 1'b1;
            w_load_val   = r_lo + WIDTH'(1);
            w_next_state = ST_UP;
          end
        end
      end

      ST_FIN: begin
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Latched configuration and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_n     <= '0;
      r_sweep <= '0;
    end else begin
      if (w_cfg_latch) begin
        r_lo <= lo;
        r_hi <= hi;
        r_n  <= n_sweeps;
      end
      if (w_sweep_clr) begin
        r_sweep <= '0;
      end else if (w_sweep_inc) begin
        r_sweep <= r_sweep + CNT_W'(1);
      end
    end
  end

  // Status outputs registered from the next state so they align with count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dir  <= 1'b1;
    end else begin
      r_busy <= (w_next_state == ST_UP) || (w_next_state == ST_DOWN);
      r_done <= (w_next_state == ST_FIN);
      r_dir  <= (w_next_state != ST_DOWN);
    end
  end

  bounded_updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .up       (w_up),
    .count    (w_count)
  );

  assign count = w_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign dir   = r_dir;

endmodule : sweep_sequencer

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: a table of sweep configurations, each expanded by
// an independent triangle-sequence model into per-cycle expected outputs.
module tb_sweep_sequencer;

  localparam int unsigned W = 3;
  localparam int unsigned C = 4;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         dir;
  } exp_t;

  // One configuration run: -1 disables the optional hold / mid-start / reset
  typedef struct {
    int lo;
    int hi;
    int n;
    int hold_idx;
    int hold_len;
    int mid_idx;
    int rst_idx;
    bit fin_start;
  } cfg_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [C-1:0] n_sweeps;
  logic         hold;
  logic [W-1:0] count;
  logic         dir;
  logic         busy;
  logic         done;

  exp_t         exp_q[$];
  exp_t         m_prev;
  logic [W-1:0] m_count;
  int           n_vec;
  int           n_err;
  int           step;

  sweep_sequencer #(
    .WIDTH (W),
    .CNT_W (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .lo       (lo),
    .hi       (hi),
    .n_sweeps (n_sweeps),
    .hold     (hold),
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic drive_step(input int tid, input logic rst_v, input logic start_v,
                            input logic hold_v, input logic [W-1:0] lo_v,
                            input logic [W-1:0] hi_v, input logic [C-1:0] n_v,
                            input exp_t e);
    exp_t want;
    exp_t got;
    @(negedge clk);
    rst      = rst_v;
    start    = start_v;
    hold     = hold_v;
    lo       = lo_v;
    hi       = hi_v;
    n_sweeps = n_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = {count, busy, done, dir};
    n_vec++;
    step++;
    if (got !== want) begin
      n_err++;
      $display("FAIL run%0d step%0d: got count=%0d busy=%0b done=%0b dir=%0b, want count=%0d busy=%0b done=%0b dir=%0b",
               tid, step, got.count, got.busy, got.done, got.dir,
               want.count, want.busy, want.done, want.dir);
    end
  endtask

  // Expand one configuration into its expected cycle sequence and apply it
  task automatic apply_run(input int tid, input cfg_t c);
    exp_t         b[$];
    exp_t         e;
    logic [W-1:0] lo_d;
    logic [W-1:0] hi_d;
    logic [C-1:0] n_d;
    lo_d = W'(c.lo);
    hi_d = W'(c.hi);
    n_d  = C'(c.n);
    step = 0;

    if (c.hi <= c.lo || c.n == 0) begin
      e.count = m_count; e.busy = 1'b0; e.done = 1'b1; e.dir = 1'b1;
      drive_step(tid, 1'b0, 1'b1, 1'b0, lo_d, hi_d, n_d, e);
      e.done = 1'b0;
      drive_step(tid, 1'b0, c.fin_start, 1'b1, lo_d, hi_d, n_d, e);
      return;
    end

    // Triangle model: first sweep starts at lo, later sweeps at lo+1
    for (int s = 0; s < c.n; s++) begin
      for (int v = (s == 0) ? c.lo : c.lo + 1; v <= c.hi; v++) begin
        e.count = W'(v); e.busy = 1'b1; e.done = 1'b0; e.dir = 1'b1;
        b.push_back(e);
      end
      for (int v = c.hi - 1; v >= c.lo; v--) begin
        e.count = W'(v); e.busy = 1'b1; e.done = 1'b0; e.dir = 1'b0;
        b.push_back(e);
      end
    end

    for (int j = 0; j < b.size(); j++) begin
      if (j > 0 && j - 1 == c.hold_idx) begin
        for (int h = 0; h < c.hold_len; h++) begin
          drive_step(tid, 1'b0, 1'b0, 1'b1, lo_d, hi_d, n_d, b[j-1]);
        end
      end
      if (j == c.rst_idx) begin
        e.count = '0; e.busy = 1'b0; e.done = 1'b0; e.dir = 1'b1;
        for (int k = 0; k < 4; k++) begin
          drive_step(tid, (k == 0), 1'b0, 1'b0, lo_d, hi_d, n_d, e);
        end
        m_count = '0;
        return;
      end
      if (j == c.mid_idx) begin
        lo_d = W'(0);
        hi_d = W'(7);
        n_d  = C'(5);
        drive_step(tid, 1'b0, 1'b1, 1'b0, lo_d, hi_d, n_d, b[j]);
      end else begin
        drive_step(tid, 1'b0, (j == 0), 1'b0, lo_d, hi_d, n_d, b[j]);
      end
    end

    e.count = W'(c.lo); e.busy = 1'b0; e.done = 1'b1; e.dir = 1'b1;
    drive_step(tid, 1'b0, 1'b0, 1'b0, lo_d, hi_d, n_d, e);
    e.done = 1'b0;
    drive_step(tid, 1'b0, c.fin_start, 1'b1, lo_d, hi_d, n_d, e);
    m_count = W'(c.lo);
  endtask

  cfg_t tbl[11];

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    lo = '0; hi = '0; n_sweeps = '0;
    n_vec = 0; n_err = 0; step = 0;
    m_count = '0;

    //           lo hi  n hidx hlen mid  rst fin_start
    tbl[0]  = '{2, 5, 1, -1, 0, -1, -1, 1'b0};
    tbl[1]  = '{4, 4, 3, -1, 0, -1, -1, 1'b0};
    tbl[2]  = '{1, 3, 0, -1, 0, -1, -1, 1'b0};
    tbl[3]  = '{0, 7, 2, -1, 0, -1, -1, 1'b1};
    tbl[4]  = '{0, 7, 1,  9, 3, -1, -1, 1'b0};
    tbl[5]  = '{1, 6, 2, -1, 0,  4, -1, 1'b0};
    tbl[6]  = '{3, 7, 2, -1, 0, -1, 10, 1'b0};
    tbl[7]  = '{0, 1, 3,  1, 2, -1, -1, 1'b0};
    tbl[8]  = '{6, 7, 1, -1, 0, -1, -1, 1'b0};
    tbl[9]  = '{5, 2, 4, -1, 0, -1, -1, 1'b0};
    tbl[10] = '{2, 6, 1, -1, 0, -1, -1, 1'b0};

    // Reset state
    m_prev.count = '0; m_prev.busy = 1'b0; m_prev.done = 1'b0; m_prev.dir = 1'b1;
    drive_step(-1, 1'b1, 1'b0, 1'b0, '0, '0, '0, m_prev);
    drive_step(-1, 1'b1, 1'b1, 1'b0, W'(1), W'(5), C'(2), m_prev);
    drive_step(-1, 1'b0, 1'b0, 1'b1, '0, '0, '0, m_prev);

    for (int i = 0; i < 11; i++) begin
      apply_run(i, tbl[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sweep_sequencer

// File: doc/sweep_sequencer.md
# sweep_sequencer

Controller that drives a bounded up/down (triangle) counter through a programmed number of sweeps between a low and high bound, then reports completion. It wraps the plain 0→7→0 gradual counter pattern with start/done handshaking, programmable bounds, sweep counting and a hold input. It sits between a control/config source and any consumer of a triangle sequence, such as a PWM or stepped-level generator.

## Interface
- WIDTH, 3, bit width of the count value and the bounds
- CNT_W, 4, bit width of the sweep-count request; maximum sweeps is 2^CNT_W-1

- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- lo  input  WIDTH  lower bound, unsigned; latched on an accepted start
- hi  input  WIDTH  upper bound, unsigned; latched on an accepted start
- n_sweeps  input  CNT_W  number of full sweeps (lo→hi→lo); latched on an accepted start
- hold  input  1  freezes all sequencing state while high
- count  output  WIDTH  current counter value
- dir  output  1  1 = counting up or idle, 0 = counting down
- busy  output  1  high in states UP and DOWN
- done  output  1  one-cycle pulse on completion or on a rejected configuration

## Operation
- States:
  - IDLE: reset state.
  - UP, DOWN: active sweeping.
  - FIN: one cycle long, drives done.
- Reset values: state=IDLE, count=0, dir=1, busy=0, done=0, sweep counter=0, latched config=0.
- IDLE with start=1:
  - Latch lo, hi and n_sweeps.
  - If hi<=lo or n_sweeps==0, go to FIN. count is unchanged and no sweep runs.
  - Otherwise count<=lo, sweep counter<=0, go to UP.
- UP:
  - If count==hi_l: count<=count-1, go to DOWN. The peak is shown for exactly one cycle.
  - Otherwise count<=count+1.
- DOWN:
  - If count!=lo_l: count<=count-1.
  - If count==lo_l, one sweep is complete. If sweep counter+1==n_l, go to FIN and count holds lo_l.
  - If count==lo_l and sweeps remain: increment the sweep counter, count<=lo_l+1, go to UP. The trough is shown for exactly one cycle.
- FIN: done=1, then go to IDLE. count holds its value in both FIN and IDLE.
- hold=1 in UP or DOWN: count, state, dir and the sweep counter are frozen. busy stays high. hold is ignored in IDLE and FIN.
- start while busy or in FIN is ignored. Changes to lo, hi or n_sweeps after acceptance have no effect.
- rst asserted mid-sweep returns every output to its reset value on the next edge. No done pulse is produced.
- Arithmetic is unsigned WIDTH-bit. The bounds guarantee no wrap-around: hi=2^WIDTH-1 and lo=0 are legal and must not overflow.

## Timing
- Accepted start in cycle t: busy=1 and count=lo from the edge ending cycle t.
- Busy duration for n sweeps is 2·(hi-lo)·n+1 cycles, plus any cycles held.
- done rises on the edge after the final count==lo cycle and is high for exactly one cycle. busy=0 in that same cycle.
- Rejected configuration: done pulses on the edge after start, and busy never rises.
- Back-to-back operation: a start is accepted in the first IDLE cycle after FIN.

## Structure
- Shared package/include holds:
  - the state encoding localparams (IDLE, UP, DOWN, FIN);
  - WIDTH and CNT_W defaults, which are shared with the counter consumers.
- One natural sub-module, bounded_updown_counter:
  - inputs: clk, rst, load, load_val, en, up;
  - output: count, WIDTH bits.
- sweep_sequencer owns the FSM, the latched config, the sweep counter and the compare logic.

## Test plan
- rst, then lo=2, hi=5, n=1, start → count 2,3,4,5,4,3,2 on consecutive cycles, then done=1 for one cycle, count stays 2.
- lo=0, hi=7, n=2 → 0..7..0 then 1..7..0, 29 busy cycles, a single done pulse, no 0 repeated at the turnaround.
- lo=4, hi=4, n=3 (and separately lo=1, hi=3, n=0) → done pulse on the next cycle, busy never high, count unchanged.
- hold high for 3 cycles while count=5 going down → count stays 5 and busy stays 1, then the sequence resumes 4,3,…; total busy length grows by 3.
- start pulsed mid-sweep with new lo/hi → ignored and the original sequence completes. Then rst mid-sweep → count=0, dir=1, busy=0, done never pulses.
